sbox_layer_seq: RTL
===================

Name: sbox_layer_seq

Overview:
- Sequencer that runs the 64-bit masked state of the inverse PRINCE round through one shared 2-share masked inverse S-box instance, one nibble per cycle.
- Sits between the round-state register and the S-box. Drives the S-box share inputs, captures the registered share outputs, and reassembles the 64-bit two-share result.
- Replaces 16 parallel S-box instances with one, trading area for 16+ cycles per layer.

Parameters:
SBOX_LAT, 1, S-box input-to-output latency in clock cycles (range 1..3).
NNIB, 16, nibbles per state. Fixed at 16. State width = 4*NNIB.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin layer; sampled only in IDLE
state_in_s0  input  64  share 0 of input state; nibble i = bits [4i+3:4i]
state_in_s1  input  64  share 1 of input state
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse: result valid
state_out_s0  output  64  share 0 of S-box layer result
state_out_s1  output  64  share 1 of S-box layer result
sb_ina  output  2  {s1[3], s0[3]} of the issued nibble
sb_inb  output  2  {s1[2], s0[2]}
sb_inc  output  2  {s1[1], s0[1]}
sb_ind  output  2  {s1[0], s0[0]}
sb_out0  input  4  S-box output share 0
sb_out1  input  4  S-box output share 1

Behaviour:
- Reset: FSM to IDLE; busy=0, done=0, state_out_s0/s1=0, all sb_in*=0, counters and capture pipe cleared.
- Reset mid-operation discards all work. No done is produced for the aborted layer.
- FSM states and transitions:
  - IDLE: start=1 latches both input shares into an internal buffer (cycle C0), then goes to ISSUE.
  - ISSUE: 16 cycles, C1..C16. Cycle C(1+i) drives nibble k_i onto sb_in*. Without the optional feature, k_i = i.
  - DRAIN: waits SBOX_LAT cycles for the last capture.
  - DONE: one cycle, C(17+SBOX_LAT). done=1, busy=0; then returns to IDLE.
- Capture: a SBOX_LAT-deep valid/index shift pipe tracks each issued nibble. When an entry exits the pipe, sb_out0/sb_out1 are written into nibble k of state_out_s0/s1 on that clock edge.
- Capture timing: a nibble issued in cycle Cj is written at the end of cycle C(j+SBOX_LAT).
- Latency: start accepted at C0 -> done at C(17+SBOX_LAT). With SBOX_LAT=1, done is at C18.
- sb_in* are 0 in every cycle that is not an ISSUE cycle.
- state_out_s0/s1 are written only by captures. After done they hold until the next layer's captures.
- Shares are never combined; no XOR of s0 with s1 anywhere in this block.
- start while busy is ignored. start in the DONE cycle is ignored. Back-to-back layers therefore need start in IDLE, at the earliest the cycle after done.
- state_in_* are sampled only at C0. Later changes have no effect on the running layer.

Optional Feature:
- Macro: SBOX_ORDER_SHUFFLE_EN.
- When defined:
  - Adds input port rnd_off [3:0].
  - rnd_off is latched at C0.
  - Issue order becomes k_i = (rnd_off + i) mod 16.
  - The capture pipe carries k so results land in the correct nibble.
  - Latency and done timing are unchanged.
- When undefined: no rnd_off port; k_i = i.

Test Plan:
- Basic layer: rst, then start with s0=0x0123456789ABCDEF, s1=0 and the real S-box (LAT=1) -> done exactly at C18; s0^s1 of the result = 0xB732FD89A6405EC1; busy high for C1..C17.
- Masked input: s1=0xA5A5A5A55A5A5A5A, s0=0x0123456789ABCDEF^s1 -> unmasked result = 0xB732FD89A6405EC1. Neither output share equals the plaintext result.
- Issue order: scoreboard sb_in* per cycle -> nibble 0 at C1, nibble 15 at C16; sb_in*=0 at C0 and C17.
- Start while busy / reset mid-run: pulse start at C5 -> ignored, done still at C18 only. Separately, rst at C8 -> busy=0, outputs=0, no done; a fresh start then completes normally.
- SBOX_LAT=3 with a behavioural 3-cycle S-box model -> done at C20, correct result.
- SBOX_ORDER_SHUFFLE_EN with rnd_off=0xD -> nibble 13 issued at C1, nibble 12 at C16; final result identical to the unshuffled run.

Source files
------------

// File: rtl/sbox_layer_seq.sv
// -----------------------------------------------------------------------------
// sbox_layer_seq
//   Feeds the 64-bit two-share state of the inverse PRINCE round through one
//   shared masked inverse S-box, one nibble per cycle, and reassembles the
//   two-share result. The shares are only routed and stored here. They are
//   never combined.
//
//   Timeline (C0 = cycle in which start is accepted):
//     C1..C16              issue nibbles k_0..k_15 on sb_in*
//     C17..C(16+SBOX_LAT)  drain the S-box pipeline
//     C(17+SBOX_LAT)       done pulse, result stable on state_out_s*
//
//   Optional build macro: SBOX_ORDER_SHUFFLE_EN
//     adds rnd_off[3:0], latched at C0; issue order k_i = (rnd_off + i) mod 16.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   start                  begin a layer (honoured only in IDLE)
//   state_in_s0/s1         input shares, nibble i = bits [4i+3:4i]
//   busy, done             busy C1..C(16+SBOX_LAT), done one-cycle pulse
//   state_out_s0/s1        output shares, written only by captures
//   sb_ina..sb_ind         {s1[b], s0[b]} of the issued nibble, bits 3..0
//   sb_out0/sb_out1        registered S-box output shares
// -----------------------------------------------------------------------------
module sbox_layer_seq #(
   parameter int SBOX_LAT = 1,   // S-box input-to-output latency, 1..3
   parameter int NNIB     = 16   // nibbles per state, fixed
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [4*NNIB-1:0] state_in_s0,
   input  logic [4*NNIB-1:0] state_in_s1,
`ifdef SBOX_ORDER_SHUFFLE_EN
   input  logic [3:0]        rnd_off,
`endif
   output logic              busy,
   output logic              done,
   output logic [4*NNIB-1:0] state_out_s0,
   output logic [4*NNIB-1:0] state_out_s1,
   output logic [1:0]        sb_ina,
   output logic [1:0]        sb_inb,
   output logic [1:0]        sb_inc,
   output logic [1:0]        sb_ind,
   input  logic [3:0]        sb_out0,
   input  logic [3:0]        sb_out1
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_e;

   state_e                     state_q;
   logic [3:0]                 cnt_q;      // issue index in ISSUE, drain count in DRAIN
   logic [4*NNIB-1:0]          buf0_q, buf1_q;
   logic [4*NNIB-1:0]          out0_q, out1_q;
   logic                       busy_q, done_q;
   logic [SBOX_LAT-1:0]        pipe_vld_q;
   logic [SBOX_LAT-1:0][3:0]   pipe_idx_q;

   logic                       issuing;
   logic [3:0]                 issue_k;
   logic [3:0]                 nib0, nib1;

`ifdef SBOX_ORDER_SHUFFLE_EN
   logic [3:0]                 off_q;
   assign issue_k = cnt_q + off_q;   // 4-bit add wraps mod 16
`else
   assign issue_k = cnt_q;
`endif

   assign issuing = (state_q == ST_ISSUE);
   assign nib0    = buf0_q[{issue_k, 2'b00} +: 4];
   assign nib1    = buf1_q[{issue_k, 2'b00} +: 4];

   // Each S-box input pair carries one bit position from both shares.
   assign sb_ina = issuing ? {nib1[3], nib0[3]} : 2'b00;
   assign sb_inb = issuing ? {nib1[2], nib0[2]} : 2'b00;
   assign sb_inc = issuing ? {nib1[1], nib0[1]} : 2'b00;
   assign sb_ind = issuing ? {nib1[0], nib0[0]} : 2'b00;

   assign busy         = busy_q;
   assign done         = done_q;
   assign state_out_s0 = out0_q;
   assign state_out_s1 = out1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         buf0_q     <= '0;
         buf1_q     <= '0;
         out0_q     <= '0;
         out1_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pipe_vld_q <= '0;
         pipe_idx_q <= '0;
`ifdef SBOX_ORDER_SHUFFLE_EN
         off_q      <= '0;
`endif
      end else begin
         done_q <= 1'b0;

         // Capture pipe: one entry per issue cycle, carrying the nibble index
         // so shuffled results still land in the right place.
         pipe_vld_q[0] <= issuing;
         pipe_idx_q[0] <= issue_k;
         for (int i = 1; i < SBOX_LAT; i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1];
            pipe_idx_q[i] <= pipe_idx_q[i-1];
         end
         if (pipe_vld_q[SBOX_LAT-1]) begin
            out0_q[{pipe_idx_q[SBOX_LAT-1], 2'b00} +: 4] <= sb_out0;
            out1_q[{pipe_idx_q[SBOX_LAT-1], 2'b00} +: 4] <= sb_out1;
         end

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  buf0_q  <= state_in_s0;
                  buf1_q  <= state_in_s1;
`ifdef SBOX_ORDER_SHUFFLE_EN
                  off_q   <= rnd_off;
`endif
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'(NNIB-1)) begin
                  cnt_q   <= '0;
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               cnt_q <= cnt_q + 4'd1;
               // The last capture happens on this edge, so the result is
               // complete in the DONE cycle.
               if (cnt_q == 4'(SBOX_LAT-1)) begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;   // start in DONE is ignored
            end
         endcase
      end
   end

endmodule
